// File: rtl/de_mw_pipe_ctrl_pkg.sv
// Shared types for the DE->MW pipeline register: opcode encoding, datapath width
// and the memory-hold state machine encoding.
package de_mw_pipe_ctrl_pkg;

   localparam int XLEN = 32;

   typedef enum logic [6:0] {
      NOP_OP      = 7'b0000000,
      R_type      = 7'b0110011,
      I_type      = 7'b0010011,
      I_type_load = 7'b0000011,
      S_type      = 7'b0100011,
      B_type      = 7'b1100011,
      J_type      = 7'b1101111,
      U_type      = 7'b0110111
   } type_opcode_e;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_state_e;

   function automatic logic is_mem_op(input type_opcode_e op);
      return (op == I_type_load) || (op == S_type);
   endfunction

endpackage

// File: rtl/de_mw_pipe_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on the data bus; flags the last permitted wait cycle.
module de_mw_pipe_ctrl_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expired
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Saturates at LAST so a missed clear can never wrap back into a short wait.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = en && (r_cnt == LAST);

endmodule

// File: rtl/de_mw_pipe_ctrl.sv
// DE->MW pipeline register with flush bubbles and a load/store hold on the data bus.
// Outputs rdMW/reg_wrMW/opcode_MW feed the forwarding unit.
module de_mw_pipe_ctrl
   import de_mw_pipe_ctrl_pkg::*;
#(
   parameter int XLEN        = de_mw_pipe_ctrl_pkg::XLEN,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   pcDE,
   input  logic [4:0]        rdDE,
   input  logic              reg_wrDE,
   input  type_opcode_e      opcode_DE,
   input  logic [XLEN-1:0]   alu_resDE,
   input  logic [XLEN-1:0]   wdataDE,
   input  logic              br_taken,
   input  logic              mem_ready,
   output logic [XLEN-1:0]   pcMW,
   output logic [4:0]        rdMW,
   output logic              reg_wrMW,
   output type_opcode_e      opcode_MW,
   output logic [XLEN-1:0]   alu_resMW,
   output logic [XLEN-1:0]   wdataMW,
   output logic              validMW,
   output logic              mem_req,
   output logic              stall,
   output logic              flush,
   output logic              bus_err
);

   pipe_state_e      r_state;
   pipe_state_e      w_state_nxt;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_alu;
   logic [XLEN-1:0]  r_wdata;
   logic [4:0]       r_rd;
   logic             r_reg_wr;
   logic             r_valid;
   logic             r_new;
   logic             r_bus_err;
   type_opcode_e     r_op;

   logic             w_in_wait;
   logic             w_first;
   logic             w_expired;
   logic             w_timeout;
   logic             w_stall;
   logic             w_flush;
   logic             w_mem_req;

   assign w_in_wait = (r_state == MEM_WAIT);
   // r_new marks the first cycle a load/store sits in MW; an aborted access stays
   // held for one cycle afterwards and must not re-issue.
   assign w_first   = !w_in_wait && r_new && r_valid && is_mem_op(r_op);
   assign w_timeout = w_expired && !mem_ready;

   de_mw_pipe_ctrl_mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (w_in_wait),
      .clr     (!w_in_wait || mem_ready || w_expired),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_mem_req   = 1'b0;
      case (r_state)
         RUN: begin
            w_mem_req = w_first;
            w_stall   = w_first && !mem_ready;
            if (w_first && !mem_ready) begin
               w_state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            w_mem_req = 1'b1;
            w_stall   = !mem_ready;
            if (mem_ready || w_expired) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
      w_flush = br_taken && !w_stall;
   end

   // br_taken qualifies the instruction currently in DE: on flush it enters MW as a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= '0;
         r_rd      <= '0;
         r_alu     <= '0;
         r_wdata   <= '0;
         r_reg_wr  <= 1'b0;
         r_valid   <= 1'b0;
         r_op      <= NOP_OP;
         r_new     <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (!w_stall) begin
            r_pc    <= pcDE;
            r_rd    <= rdDE;
            r_alu   <= alu_resDE;
            r_wdata <= wdataDE;
            r_new   <= 1'b1;
            if (w_flush) begin
               r_valid  <= 1'b0;
               r_reg_wr <= 1'b0;
               r_op     <= NOP_OP;
            end else begin
               r_valid  <= 1'b1;
               r_reg_wr <= reg_wrDE;
               r_op     <= opcode_DE;
            end
         end else begin
            r_new <= 1'b0;
            if (w_timeout) begin
               r_reg_wr <= 1'b0;
            end
         end
      end
   end

   assign pcMW      = r_pc;
   assign rdMW      = r_rd;
   assign reg_wrMW  = r_reg_wr && r_valid && (r_rd != 5'd0);
   assign opcode_MW = r_op;
   assign alu_resMW = r_alu;
   assign wdataMW   = r_wdata;
   assign validMW   = r_valid;
   assign mem_req   = w_mem_req;
   assign stall     = w_stall;
   assign flush     = w_flush;
   assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_de_mw_pipe_ctrl.sv
// Bench for de_mw_pipe_ctrl: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a cycle-level reference model.
module tb_de_mw_pipe_ctrl;
   import de_mw_pipe_ctrl_pkg::*;

   localparam int XL  = 32;
   localparam int TMO = 16;

   logic            clk;
   logic            rst;
   logic [XL-1:0]   pcDE;
   logic [4:0]      rdDE;
   logic            reg_wrDE;
   type_opcode_e    opcode_DE;
   logic [XL-1:0]   alu_resDE;
   logic [XL-1:0]   wdataDE;
   logic            br_taken;
   logic            mem_ready;
   logic [XL-1:0]   pcMW;
   logic [4:0]      rdMW;
   logic            reg_wrMW;
   type_opcode_e    opcode_MW;
   logic [XL-1:0]   alu_resMW;
   logic [XL-1:0]   wdataMW;
   logic            validMW;
   logic            mem_req;
   logic            stall;
   logic            flush;
   logic            bus_err;

   int n_chk;
   int n_err;

   de_mw_pipe_ctrl #(.XLEN(XL), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pcDE(pcDE), .rdDE(rdDE), .reg_wrDE(reg_wrDE),
      .opcode_DE(opcode_DE), .alu_resDE(alu_resDE), .wdataDE(wdataDE),
      .br_taken(br_taken), .mem_ready(mem_ready), .pcMW(pcMW), .rdMW(rdMW),
      .reg_wrMW(reg_wrMW), .opcode_MW(opcode_MW), .alu_resMW(alu_resMW),
      .wdataMW(wdataMW), .validMW(validMW), .mem_req(mem_req), .stall(stall),
      .flush(flush), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_mw(input string t, input logic v, input logic [4:0] rd,
                         input logic wr, input type_opcode_e op);
      chk({t, ".validMW"},   64'(validMW),   64'(v));
      chk({t, ".rdMW"},      64'(rdMW),      64'(rd));
      chk({t, ".reg_wrMW"},  64'(reg_wrMW),  64'(wr));
      chk({t, ".opcode_MW"}, 64'(opcode_MW), 64'(op));
   endtask

   task automatic chk_ctl(input string t, input logic st, input logic fl, input logic rq);
      chk({t, ".stall"},   64'(stall),   64'(st));
      chk({t, ".flush"},   64'(flush),   64'(fl));
      chk({t, ".mem_req"}, 64'(mem_req), 64'(rq));
   endtask

   // One cycle: drive DE at the falling edge, settle, leave inputs for the next rising edge.
   task automatic step(input type_opcode_e op, input logic [4:0] rd, input logic wr,
                       input logic br, input logic mr);
      @(negedge clk);
      rst       = 1'b0;
      opcode_DE = op;
      rdDE      = rd;
      reg_wrDE  = wr;
      br_taken  = br;
      mem_ready = mr;
      pcDE      = 32'h2000 + {25'd0, rd, 2'b00};
      alu_resDE = 32'hA000 + {27'd0, rd};
      wdataDE   = 32'hD000 + {27'd0, rd};
      #1;
   endtask

   typedef struct {
      logic [4:0]   rd;
      logic         wr;
      type_opcode_e op;
      logic         br;
      logic         mr;
      logic         e_valid;
      logic [4:0]   e_rd;
      logic         e_wr;
      type_opcode_e e_op;
      logic         e_stall;
      logic         e_flush;
      logic         e_req;
   } vec_t;

   vec_t tv [12];

   // Reference model: the instruction held in MW plus the age of its bus access.
   logic          m_valid, m_wr, m_berr;
   logic [4:0]    m_rd;
   type_opcode_e  m_op;
   logic [XL-1:0] m_pc, m_alu, m_wd;
   int            m_age;

   task automatic model_edge();
      if (rst) begin
         m_valid = 1'b0; m_wr = 1'b0; m_rd = 5'd0; m_op = NOP_OP;
         m_pc = '0; m_alu = '0; m_wd = '0; m_age = -1; m_berr = 1'b0;
      end else begin
         m_berr = 1'b0;
         if ((m_age >= 0) && !mem_ready) begin
            if (m_age == TMO) begin
               m_wr = 1'b0; m_age = -1; m_berr = 1'b1;
            end else begin
               m_age++;
            end
         end else begin
            m_valid = !br_taken;
            m_wr    = br_taken ? 1'b0 : reg_wrDE;
            m_op    = br_taken ? NOP_OP : opcode_DE;
            m_rd = rdDE; m_pc = pcDE; m_alu = alu_resDE; m_wd = wdataDE;
            m_age = (m_valid && (m_op == I_type_load || m_op == S_type)) ? 0 : -1;
         end
      end
   endtask

   task automatic model_check(input int c);
      logic e_stall;
      string t;
      t = $sformatf("rnd%0d", c);
      e_stall = (m_age >= 0) && !mem_ready;
      chk_mw(t, m_valid, m_rd, m_wr && m_valid && (m_rd != 5'd0), m_op);
      chk_ctl(t, e_stall, br_taken && !e_stall, m_age >= 0);
      chk({t, ".pcMW"},      64'(pcMW),      64'(m_pc));
      chk({t, ".alu_resMW"}, 64'(alu_resMW), 64'(m_alu));
      chk({t, ".wdataMW"},   64'(wdataMW),   64'(m_wd));
      chk({t, ".bus_err"},   64'(bus_err),   64'(m_berr));
   endtask

   initial begin
      int n_stall;
      int deaf;
      logic seen;
      n_chk = 0;
      n_err = 0;

      tv[0]  = '{5'd5,  1'b1, R_type, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, NOP_OP, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{5'd6,  1'b1, R_type, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, R_type, 1'b0, 1'b0, 1'b0};
      tv[2]  = '{5'd9,  1'b1, I_type, 1'b1, 1'b0, 1'b1, 5'd6,  1'b1, R_type, 1'b0, 1'b1, 1'b0};
      tv[3]  = '{5'd10, 1'b1, R_type, 1'b0, 1'b0, 1'b0, 5'd9,  1'b0, NOP_OP, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{5'd0,  1'b1, R_type, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1, R_type, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{5'd11, 1'b0, I_type, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, R_type, 1'b0, 1'b0, 1'b0};
      tv[6]  = '{5'd12, 1'b1, R_type, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, I_type, 1'b0, 1'b1, 1'b0};
      tv[7]  = '{5'd0,  1'b0, B_type, 1'b1, 1'b0, 1'b0, 5'd12, 1'b0, NOP_OP, 1'b0, 1'b1, 1'b0};
      tv[8]  = '{5'd13, 1'b1, R_type, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, NOP_OP, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{5'd0,  1'b0, S_type, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1, R_type, 1'b0, 1'b0, 1'b0};
      tv[10] = '{5'd14, 1'b1, R_type, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, S_type, 1'b0, 1'b0, 1'b1};
      tv[11] = '{5'd15, 1'b1, R_type, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1, R_type, 1'b0, 1'b0, 1'b0};

      // Reset state
      @(negedge clk);
      rst = 1'b1; opcode_DE = I_type_load; rdDE = 5'd3; reg_wrDE = 1'b1;
      br_taken = 1'b0; mem_ready = 1'b0; pcDE = 32'h1; alu_resDE = 32'h2; wdataDE = 32'h3;
      @(negedge clk);
      #1;
      chk_mw("reset", 1'b0, 5'd0, 1'b0, NOP_OP);
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset.pcMW", 64'(pcMW), 64'd0);
      chk("reset.bus_err", 64'(bus_err), 64'd0);

      // ALU stream, x0 suppression, flush bubbles, single-cycle store
      for (int i = 0; i < 12; i++) begin
         step(tv[i].op, tv[i].rd, tv[i].wr, tv[i].br, tv[i].mr);
         chk_mw($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_rd, tv[i].e_wr, tv[i].e_op);
         chk_ctl($sformatf("vec%0d", i), tv[i].e_stall, tv[i].e_flush, tv[i].e_req);
      end

      // Load x7, bus completes on the fourth MW cycle
      step(I_type_load, 5'd7, 1'b1, 1'b0, 1'b0);
      step(R_type, 5'd8, 1'b1, 1'b0, 1'b0);
      chk_mw("ld.c1", 1'b1, 5'd7, 1'b1, I_type_load);
      chk_ctl("ld.c1", 1'b1, 1'b0, 1'b1);
      chk("ld.c1.pcMW", 64'(pcMW), 64'h201C);
      chk("ld.c1.alu_resMW", 64'(alu_resMW), 64'hA007);
      step(R_type, 5'd8, 1'b1, 1'b0, 1'b0);
      chk_ctl("ld.c2", 1'b1, 1'b0, 1'b1);
      chk("ld.c2.rdMW", 64'(rdMW), 64'd7);
      step(R_type, 5'd8, 1'b1, 1'b0, 1'b0);
      chk_ctl("ld.c3", 1'b1, 1'b0, 1'b1);
      step(R_type, 5'd8, 1'b1, 1'b0, 1'b1);
      chk_ctl("ld.c4", 1'b0, 1'b0, 1'b1);
      chk("ld.c4.rdMW", 64'(rdMW), 64'd7);
      step(R_type, 5'd20, 1'b1, 1'b0, 1'b0);
      chk_mw("ld.c5", 1'b1, 5'd8, 1'b1, R_type);
      chk_ctl("ld.c5", 1'b0, 1'b0, 1'b0);

      // Back-to-back loads
      step(I_type_load, 5'd21, 1'b1, 1'b0, 1'b0);
      step(I_type_load, 5'd22, 1'b1, 1'b0, 1'b0);
      chk_ctl("b2b.c1", 1'b1, 1'b0, 1'b1);
      step(I_type_load, 5'd22, 1'b1, 1'b0, 1'b1);
      chk_ctl("b2b.c2", 1'b0, 1'b0, 1'b1);
      step(R_type, 5'd23, 1'b1, 1'b0, 1'b0);
      chk_mw("b2b.c3", 1'b1, 5'd22, 1'b1, I_type_load);
      chk_ctl("b2b.c3", 1'b1, 1'b0, 1'b1);
      step(R_type, 5'd23, 1'b1, 1'b0, 1'b1);
      chk_ctl("b2b.c4", 1'b0, 1'b0, 1'b1);
      step(R_type, 5'd24, 1'b1, 1'b0, 1'b0);
      chk_mw("b2b.c5", 1'b1, 5'd23, 1'b1, R_type);

      // br_taken while the load waits
      step(I_type_load, 5'd3, 1'b1, 1'b0, 1'b0);
      step(R_type, 5'd4, 1'b1, 1'b1, 1'b0);
      chk_ctl("brw.c1", 1'b1, 1'b0, 1'b1);
      step(R_type, 5'd4, 1'b1, 1'b1, 1'b0);
      chk_ctl("brw.c2", 1'b1, 1'b0, 1'b1);
      chk("brw.c2.rdMW", 64'(rdMW), 64'd3);
      step(R_type, 5'd4, 1'b1, 1'b1, 1'b1);
      chk_ctl("brw.c3", 1'b0, 1'b1, 1'b1);
      step(R_type, 5'd5, 1'b1, 1'b0, 1'b0);
      chk_mw("brw.c4", 1'b0, 5'd4, 1'b0, NOP_OP);
      chk("brw.c4.flush", 64'(flush), 64'd0);

      // Reset during MEM_WAIT with an rd=0 load
      step(I_type_load, 5'd0, 1'b1, 1'b0, 1'b0);
      step(R_type, 5'd1, 1'b1, 1'b0, 1'b0);
      chk("rstw.c1.reg_wrMW", 64'(reg_wrMW), 64'd0);
      chk("rstw.c1.stall", 64'(stall), 64'd1);
      step(R_type, 5'd1, 1'b1, 1'b0, 1'b0);
      chk("rstw.c2.reg_wrMW", 64'(reg_wrMW), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstw.c3.reg_wrMW", 64'(reg_wrMW), 64'd0);
      step(R_type, 5'd1, 1'b1, 1'b0, 1'b0);
      chk_mw("rstw.c4", 1'b0, 5'd0, 1'b0, NOP_OP);
      chk_ctl("rstw.c4", 1'b0, 1'b0, 1'b0);
      chk("rstw.c4.bus_err", 64'(bus_err), 64'd0);

      // Load that never completes: stalls for the first cycle plus MEM_TIMEOUT wait cycles
      step(I_type_load, 5'd24, 1'b1, 1'b0, 1'b0);
      n_stall = 0;
      seen = 1'b0;
      for (int k = 0; k < 3 * TMO; k++) begin
         step(R_type, 5'd25, 1'b1, 1'b0, 1'b0);
         if (bus_err) begin
            seen = 1'b1;
            chk_mw("tmo.err", 1'b1, 5'd24, 1'b0, I_type_load);
            chk_ctl("tmo.err", 1'b0, 1'b0, 1'b0);
            break;
         end
         if (stall) n_stall++;
      end
      chk("tmo.seen", 64'(seen), 64'd1);
      chk("tmo.stall_cycles", 64'(n_stall), 64'(TMO + 1));
      step(R_type, 5'd26, 1'b1, 1'b0, 1'b0);
      chk("tmo.next.bus_err", 64'(bus_err), 64'd0);
      chk_mw("tmo.next", 1'b1, 5'd25, 1'b1, R_type);

      // Randomized traffic against the model
      deaf = 0;
      for (int c = 0; c < 2000; c++) begin
         int unsigned k;
         @(negedge clk);
         rst = (c == 0) || ($urandom_range(0, 199) == 0);
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2: opcode_DE = I_type_load;
            3, 4:    opcode_DE = S_type;
            5:       opcode_DE = I_type;
            6:       opcode_DE = B_type;
            7:       opcode_DE = J_type;
            8:       opcode_DE = U_type;
            default: opcode_DE = R_type;
         endcase
         rdDE      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         reg_wrDE  = ($urandom_range(0, 1) == 1);
         br_taken  = ($urandom_range(0, 6) == 0);
         pcDE      = $urandom;
         alu_resDE = $urandom;
         wdataDE   = $urandom;
         if (deaf > 0) begin
            mem_ready = 1'b0;
            deaf--;
         end else begin
            mem_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) deaf = 24;
         end
         #1;
         if (c > 0) model_check(c);
         model_edge();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
